// File: rtl/mux_scan_controller.sv
// mux_scan_controller: walks the 4:1 mux selects over the enabled channels,
// samples w at the end of each dwell, and hands 4-bit frames to a consumer
// over valid/ready, either once or continuously.
module mux_scan_controller #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               continuous,
   input  logic [3:0]         chan_en,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               w,
   output logic               s0,
   output logic               s1,
   output logic [3:0]         frame,
   output logic               frame_valid,
   input  logic               frame_ready,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;

   localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t             state, state_nx;
   logic [3:0]         mask, mask_nx;
   logic [DWELL_W-1:0] dwell_eff, dwell_eff_nx;
   logic [DWELL_W-1:0] cnt, cnt_nx;
   logic [1:0]         ch, ch_nx;
   logic [3:0]         shadow, shadow_nx;
   logic [3:0]         frame_nx;
   logic               frame_valid_nx, overrun_nx;
   logic [DWELL_W-1:0] dwell_in;
   logic [3:0]         done_frame;
   logic [2:0]         nxt;
   logic               out_free, to_hold;

   // lowest enabled channel; only called with a non-zero mask
   function automatic logic [1:0] lowest(input logic [3:0] m);
      lowest = 2'd0;
      for (int k = 3; k >= 0; k--)
         if (m[k]) lowest = 2'(k);
   endfunction

   // first enabled channel above cur; bit 2 flags that one exists
   function automatic logic [2:0] above(input logic [3:0] m, input logic [1:0] cur);
      above = 3'b000;
      for (int k = 3; k >= 0; k--)
         if (m[k] && (k > int'(cur))) above = {1'b1, 2'(k)};
   endfunction

   // a dwell of 0 behaves like 1
   assign dwell_in = (dwell == '0) ? ONE : dwell;

   assign s0      = ch[1];
   assign s1      = ch[0];
   assign busy    = (state != IDLE);

   // next-state and datapath updates
   always_comb begin
      state_nx       = state;
      mask_nx        = mask;
      dwell_eff_nx   = dwell_eff;
      cnt_nx         = cnt;
      ch_nx          = ch;
      shadow_nx      = shadow;
      frame_nx       = frame;
      overrun_nx     = 1'b0;
      frame_valid_nx = frame_valid & ~frame_ready;
      done_frame     = shadow;
      done_frame[ch] = w;
      nxt            = above(mask, ch);
      out_free       = ~frame_valid | frame_ready;
      to_hold        = 1'b0;
      case (state)
         IDLE: begin
            if (start && (chan_en != 4'd0)) begin
               mask_nx      = chan_en;
               dwell_eff_nx = dwell_in;
               cnt_nx       = dwell_in - ONE;
               ch_nx        = lowest(chan_en);
               shadow_nx    = 4'd0;
               state_nx     = DWELL;
            end
         end
         DWELL: begin
            if (cnt != '0) begin
               cnt_nx = cnt - ONE;
            end else if (nxt[2]) begin
               shadow_nx = done_frame;
               ch_nx     = nxt[1:0];
               cnt_nx    = dwell_eff - ONE;
            end else begin
               // frame boundary: deliver, park in HOLD, or overwrite
               if (out_free) begin
                  frame_nx       = done_frame;
                  frame_valid_nx = 1'b1;
               end else if (!continuous) begin
                  shadow_nx = done_frame;
                  to_hold   = 1'b1;
                  state_nx  = HOLD;
               end else begin
                  frame_nx   = done_frame;
                  overrun_nx = 1'b1;
               end
               if (!to_hold) begin
                  if (continuous && (chan_en != 4'd0)) begin
                     mask_nx      = chan_en;
                     dwell_eff_nx = dwell_in;
                     cnt_nx       = dwell_in - ONE;
                     ch_nx        = lowest(chan_en);
                     shadow_nx    = 4'd0;
                  end else begin
                     ch_nx    = 2'd0;
                     state_nx = IDLE;
                  end
               end
            end
         end
         HOLD: begin
            // selects stay on the last channel until the consumer drains
            if (frame_ready) begin
               frame_nx       = shadow;
               frame_valid_nx = 1'b1;
               ch_nx          = 2'd0;
               state_nx       = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mask        <= 4'd0;
         dwell_eff   <= ONE;
         cnt         <= '0;
         ch          <= 2'd0;
         shadow      <= 4'd0;
         frame       <= 4'd0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nx;
         mask        <= mask_nx;
         dwell_eff   <= dwell_eff_nx;
         cnt         <= cnt_nx;
         ch          <= ch_nx;
         shadow      <= shadow_nx;
         frame       <= frame_nx;
         frame_valid <= frame_valid_nx;
         overrun     <= overrun_nx;
      end
   end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: a schedule-queue model of the scan checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mux_scan_controller;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst, start, continuous, frame_ready, w;
   logic [3:0]    chan_en;
   logic [DW-1:0] dwell;
   logic          s0, s1, frame_valid, busy, overrun;
   logic [3:0]    frame;
   logic [3:0]    muxin;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // the mux itself: select {s0,s1} picks channel k
   assign w = muxin[{s0, s1}];

   mux_scan_controller #(.DWELL_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .chan_en(chan_en), .dwell(dwell), .w(w), .s0(s0), .s1(s1),
      .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .busy(busy), .overrun(overrun)
   );

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: one queue entry per cycle naming the channel driven in that cycle
   int         sched[$];
   bit         m_busy, m_hold, m_fv, m_over, model_on = 1'b0;
   logic [3:0] m_acc, m_shadow, m_frame;
   int         m_last;

   task automatic build(input logic [3:0] en, input logic [DW-1:0] d);
      int n;
      n = (d == 0) ? 1 : int'(d);
      sched.delete();
      for (int k = 0; k < 4; k++)
         if (en[k])
            for (int j = 0; j < n; j++) sched.push_back(k);
   endtask

   always @(posedge clk) begin : model
      int c;
      bit last, free;
      m_over = 1'b0;
      if (rst) begin
         m_busy = 0; m_hold = 0; m_fv = 0;
         m_acc = 0; m_shadow = 0; m_frame = 0; m_last = 0;
         sched.delete();
         model_on = 1'b1;
      end else if (!m_busy) begin
         if (m_fv && frame_ready) m_fv = 0;
         if (start && chan_en != 0) begin
            build(chan_en, dwell);
            m_acc = 0;
            m_busy = 1;
         end
      end else if (m_hold) begin
         if (frame_ready) begin
            m_frame = m_shadow; m_fv = 1; m_hold = 0; m_busy = 0;
         end
      end else begin
         c = sched.pop_front();
         last = (sched.size() == 0) || (sched[0] != c);
         if (last) m_acc[c] = muxin[c];
         if (sched.size() != 0) begin
            if (m_fv && frame_ready) m_fv = 0;
         end else begin
            free = !m_fv || frame_ready;
            if (free) begin
               m_frame = m_acc; m_fv = 1;
            end else if (!continuous) begin
               m_hold = 1; m_shadow = m_acc; m_last = c;
            end else begin
               m_frame = m_acc; m_over = 1;
            end
            if (!m_hold) begin
               if (continuous && chan_en != 0) begin
                  build(chan_en, dwell);
                  m_acc = 0;
               end else begin
                  m_busy = 0;
               end
            end
         end
      end
   end

   // per-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin : compare
      logic [1:0] es;
      if (model_on) begin
         es = !m_busy ? 2'b00 : (m_hold ? 2'(m_last) : 2'(sched[0]));
         chk("sel",         {2'b00, s0, s1},     {2'b00, es});
         chk("frame",       frame,               m_frame);
         chk("frame_valid", {3'b000, frame_valid}, {3'b000, m_fv});
         chk("busy",        {3'b000, busy},      {3'b000, m_busy});
         chk("overrun",     {3'b000, overrun},   {3'b000, m_over});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [3:0] act, input logic [3:0] exp);
      chk(nm, act, exp);
   endtask

   initial begin
      rst = 1; start = 0; continuous = 0; chan_en = 0; dwell = 0;
      frame_ready = 0; muxin = 0;
      tick(); tick();
      rst = 0;

      // 1: reset in the middle of a dwell, then a normal single-channel scan
      chan_en = 4'b1111; dwell = 3; muxin = 4'b1111;
      start = 1; tick(); start = 0;
      tick(); tick();
      lit("t1_busy_pre", {3'b0, busy}, 4'd1);
      rst = 1; tick(); tick(); rst = 0;
      lit("t1_sel",   {2'b0, s0, s1}, 4'd0);
      lit("t1_frame", frame, 4'd0);
      lit("t1_fv",    {3'b0, frame_valid}, 4'd0);
      lit("t1_busy",  {3'b0, busy}, 4'd0);
      chan_en = 4'b0001; dwell = 1; muxin = 4'b0001;
      start = 1; tick(); start = 0;
      lit("t1_busy2", {3'b0, busy}, 4'd1);
      tick();
      lit("t1_frame2", frame, 4'b0001);
      lit("t1_fv2",    {3'b0, frame_valid}, 4'd1);
      frame_ready = 1; tick(); frame_ready = 0;
      lit("t1_drain", {3'b0, frame_valid}, 4'd0);

      // 2: all channels, dwell 2, a=1 b=0 c=1 d=1
      muxin = 4'b1101; chan_en = 4'b1111; dwell = 2;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 8; i++) begin
         lit("t2_sel", {2'b0, s0, s1}, 4'(i / 2));
         lit("t2_fv",  {3'b0, frame_valid}, 4'd0);
         tick();
      end
      lit("t2_frame", frame, 4'b1101);
      lit("t2_fv1",   {3'b0, frame_valid}, 4'd1);
      lit("t2_busy",  {3'b0, busy}, 4'd0);
      tick(); tick();
      lit("t2_held",  frame, 4'b1101);
      frame_ready = 1; tick(); frame_ready = 0;
      lit("t2_drain", {3'b0, frame_valid}, 4'd0);

      // 3: sparse mask, dwell 0 behaves as 1; disabled bits read 0
      muxin = 4'b1111; chan_en = 4'b1010; dwell = 0;
      start = 1; tick(); start = 0;
      lit("t3_sel_b", {2'b0, s0, s1}, 4'd1);
      tick();
      lit("t3_sel_d", {2'b0, s0, s1}, 4'd3);
      lit("t3_fv0",   {3'b0, frame_valid}, 4'd0);
      tick();
      lit("t3_frame", frame, 4'b1010);
      lit("t3_fv1",   {3'b0, frame_valid}, 4'd1);
      frame_ready = 1; tick(); frame_ready = 0;

      // 4: continuous mode with a stalled consumer
      muxin = 4'b0001; chan_en = 4'b0001; dwell = 1; continuous = 1;
      start = 1; tick(); start = 0;
      tick();
      lit("t4_first_ovr", {3'b0, overrun}, 4'd0);
      lit("t4_first_fv",  {3'b0, frame_valid}, 4'd1);
      tick();
      lit("t4_ovr",       {3'b0, overrun}, 4'd1);
      muxin = 4'b0000; tick();
      lit("t4_reload",    frame, 4'b0000);
      lit("t4_ovr2",      {3'b0, overrun}, 4'd1);
      frame_ready = 1; tick();
      lit("t4_rdy_ovr",   {3'b0, overrun}, 4'd0);
      lit("t4_busy",      {3'b0, busy}, 4'd1);
      continuous = 0; tick();
      lit("t4_stop_busy", {3'b0, busy}, 4'd0);
      lit("t4_stop_fv",   {3'b0, frame_valid}, 4'd1);
      tick(); frame_ready = 0;
      lit("t4_drain",     {3'b0, frame_valid}, 4'd0);

      // 5: single-shot completion while the previous frame is unread
      muxin = 4'b0101; chan_en = 4'b0001; dwell = 2;
      start = 1; tick(); start = 0;
      tick(); tick();
      lit("t5_f1", frame, 4'b0001);
      chan_en = 4'b0100;
      start = 1; tick(); start = 0;
      tick(); tick();
      lit("t5_hold_busy", {3'b0, busy}, 4'd1);
      lit("t5_hold_sel",  {2'b0, s0, s1}, 4'd2);
      lit("t5_hold_frm",  frame, 4'b0001);
      tick();
      lit("t5_still",     frame, 4'b0001);
      frame_ready = 1; tick();
      lit("t5_shadow",    frame, 4'b0100);
      lit("t5_fv",        {3'b0, frame_valid}, 4'd1);
      lit("t5_idle",      {3'b0, busy}, 4'd0);
      tick(); frame_ready = 0;
      lit("t5_drain",     {3'b0, frame_valid}, 4'd0);

      // 6: empty-mask start is ignored; start mid-scan changes nothing
      chan_en = 4'b0000; start = 1; tick(); start = 0;
      lit("t6_nostart", {3'b0, busy}, 4'd0);
      chan_en = 4'b1111; dwell = 1; muxin = 4'b0101;
      start = 1; tick();
      lit("t6_sel0", {2'b0, s0, s1}, 4'd0);
      chan_en = 4'b0011; tick();
      lit("t6_sel1", {2'b0, s0, s1}, 4'd1);
      tick();
      lit("t6_sel2", {2'b0, s0, s1}, 4'd2);
      start = 0; tick();
      lit("t6_sel3", {2'b0, s0, s1}, 4'd3);
      tick();
      lit("t6_frame", frame, 4'b0101);
      lit("t6_busy",  {3'b0, busy}, 4'd0);
      frame_ready = 1; tick(); frame_ready = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
